// File: rtl/alive_pkg.sv
// Shared types and melody contents for alive_tone_sequencer: FSM states,
// the note entry layout, scale half-periods and 7-segment patterns.
package alive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] half_period;
    logic [7:0]  duration;
    logic [7:0]  pattern;
  } note_t;

  // Half-periods in clock cycles for a 50 MHz clock; zero marks a rest.
  localparam logic [15:0] HP_REST    = 16'd0;
  localparam logic [15:0] HP_C5      = 16'd47778;
  localparam logic [15:0] HP_E5      = 16'd37922;
  localparam logic [15:0] HP_G5      = 16'd31888;
  localparam logic [15:0] HP_C6      = 16'd23889;
  localparam logic [15:0] HP_TEST_LO = 16'd3;
  localparam logic [15:0] HP_TEST_HI = 16'd2;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_DP    = 8'h80;
  localparam logic [7:0] DUR_END   = 8'd0;

  function automatic note_t melody_entry(input logic test_sel, input int idx);
    note_t e;
    e = {HP_REST, DUR_END, SEG_BLANK};
    if (test_sel) begin
      case (idx)
        0:       e = {HP_TEST_LO, 8'd2, SEG_1};
        1:       e = {HP_REST,    8'd1, SEG_2};
        2:       e = {HP_TEST_HI, 8'd1, SEG_3};
        default: e = {HP_REST, DUR_END, SEG_BLANK};
      endcase
    end else begin
      case (idx)
        0:       e = {HP_C5,   8'd25, SEG_1};
        1:       e = {HP_E5,   8'd25, SEG_2};
        2:       e = {HP_G5,   8'd25, SEG_3};
        3:       e = {HP_C6,   8'd50, SEG_4};
        4:       e = {HP_REST, 8'd25, SEG_DP};
        5:       e = {HP_G5,   8'd25, SEG_5};
        6:       e = {HP_C6,   8'd50, SEG_1 | SEG_DP};
        default: e = {HP_REST, DUR_END, SEG_BLANK};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/alive_melody_rom.sv
// Melody ROM with a registered read; contents come from alive_pkg::melody_entry.
module alive_melody_rom
  import alive_pkg::*;
#(
  parameter int NOTE_COUNT  = 8,
  parameter int DIV_W       = 16,
  parameter int DUR_W       = 8,
  parameter bit TEST_MELODY = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NOTE_COUNT)-1:0] addr,
  output logic [DIV_W-1:0]              half_period,
  output logic [DUR_W-1:0]              duration,
  output logic [7:0]                    pattern
);

  note_t entry_s;

  // Table lookup for the requested entry.
  always_comb begin
    entry_s = melody_entry(TEST_MELODY, int'(addr));
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_period <= {DIV_W{1'b0}};
      duration    <= {DUR_W{1'b0}};
      pattern     <= 8'h00;
    end else begin
      half_period <= DIV_W'(entry_s.half_period);
      duration    <= DUR_W'(entry_s.duration);
      pattern     <= entry_s.pattern;
    end
  end

endmodule

// File: rtl/alive_tone_sequencer.sv
// Plays the melody ROM as a square wave on speaker and shows each note's pattern on seg.
// Define ALIVE_GAP_EN to insert GAP_TICKS silent ticks between notes.
module alive_tone_sequencer
  import alive_pkg::*;
#(
  parameter int NOTE_COUNT  = 8,
  parameter int DIV_W       = 16,
  parameter int DUR_W       = 8,
  parameter int TICK_DIV    = 10000,
  parameter int GAP_TICKS   = 1,
  parameter bit TEST_MELODY = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  output logic                          speaker,
  output logic [7:0]                    seg,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NOTE_COUNT)-1:0] note_idx
);

  localparam int IDX_W = $clog2(NOTE_COUNT);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTE_COUNT - 1);

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  note_idx_r, note_idx_s;
  logic [PRE_W-1:0]  presc_r, presc_s;
  logic [CNT_W-1:0]  dur_cnt_r, dur_cnt_s;
  logic [DIV_W-1:0]  tone_cnt_r, tone_cnt_s;
  logic              speaker_r, speaker_s;
  logic [7:0]        seg_r, seg_s;
  logic              busy_r, done_r;
  logic [DIV_W-1:0]  rom_hp_s;
  logic [DUR_W-1:0]  rom_duration_s;
  logic [7:0]        rom_pattern_s;
  logic              tick_s, tone_wrap_s, play_last_s, rom_rest_s;
  logic [CNT_W:0]    dur_inc_s;

  // The ROM is addressed with the next index so the entry is ready during LOAD.
  alive_melody_rom #(
    .NOTE_COUNT (NOTE_COUNT),
    .DIV_W      (DIV_W),
    .DUR_W      (DUR_W),
    .TEST_MELODY(TEST_MELODY)
  ) u_rom (
    .clk        (clk),
    .reset      (reset),
    .addr       (note_idx_s),
    .half_period(rom_hp_s),
    .duration   (rom_duration_s),
    .pattern    (rom_pattern_s)
  );

  assign tick_s      = (presc_r == PRE_W'(TICK_DIV - 1));
  assign rom_rest_s  = (rom_hp_s == {DIV_W{1'b0}});
  assign tone_wrap_s = (state_r == ST_PLAY) && !rom_rest_s && (tone_cnt_r == rom_hp_s - DIV_W'(1));
  assign dur_inc_s   = {1'b0, dur_cnt_r} + (CNT_W + 1)'(1);
  assign play_last_s = (dur_inc_s == (CNT_W + 1)'(rom_duration_s));

  // Next-state, counter and output decode.
  always_comb begin
    state_s    = state_r;
    note_idx_s = note_idx_r;
    presc_s    = presc_r;
    dur_cnt_s  = dur_cnt_r;
    tone_cnt_s = tone_cnt_r;
    if (stop) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s    = ST_LOAD;
            note_idx_s = {IDX_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_LOAD: begin
          presc_s    = {PRE_W{1'b0}};
          dur_cnt_s  = {CNT_W{1'b0}};
          tone_cnt_s = {DIV_W{1'b0}};
          if (rom_duration_s == DUR_W'(0)) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_PLAY: begin
          presc_s    = tick_s ? {PRE_W{1'b0}} : presc_r + PRE_W'(1);
          tone_cnt_s = (tone_wrap_s || rom_rest_s) ? {DIV_W{1'b0}} : tone_cnt_r + DIV_W'(1);
          if (tick_s && play_last_s) begin
            dur_cnt_s = {CNT_W{1'b0}};
            if (note_idx_r == IDX_LAST) begin
              state_s = ST_DONE;
            end else begin
`ifdef ALIVE_GAP_EN
              state_s = ST_GAP;
`else
              state_s    = ST_LOAD;
              note_idx_s = note_idx_r + IDX_W'(1);
`endif
            end
          end else if (tick_s) begin
            dur_cnt_s = dur_cnt_r + CNT_W'(1);
          end else begin
            dur_cnt_s = dur_cnt_r;
          end
        end
`ifdef ALIVE_GAP_EN
        ST_GAP: begin
          presc_s = tick_s ? {PRE_W{1'b0}} : presc_r + PRE_W'(1);
          if (tick_s && (dur_inc_s == (CNT_W + 1)'(GAP_TICKS))) begin
            dur_cnt_s  = {CNT_W{1'b0}};
            state_s    = ST_LOAD;
            note_idx_s = note_idx_r + IDX_W'(1);
          end else if (tick_s) begin
            dur_cnt_s = dur_cnt_r + CNT_W'(1);
          end else begin
            dur_cnt_s = dur_cnt_r;
          end
        end
`endif
        ST_DONE: begin
          if (loop_en) begin
            state_s    = ST_LOAD;
            note_idx_s = {IDX_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they are registered with it.
    if (state_s == ST_PLAY) begin
      speaker_s = tone_wrap_s ? ~speaker_r : speaker_r;
      seg_s     = rom_pattern_s;
    end else begin
      speaker_s = 1'b0;
      seg_s     = 8'h00;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      note_idx_r <= {IDX_W{1'b0}};
      presc_r    <= {PRE_W{1'b0}};
      dur_cnt_r  <= {CNT_W{1'b0}};
      tone_cnt_r <= {DIV_W{1'b0}};
      speaker_r  <= 1'b0;
      seg_r      <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      note_idx_r <= note_idx_s;
      presc_r    <= presc_s;
      dur_cnt_r  <= dur_cnt_s;
      tone_cnt_r <= tone_cnt_s;
      speaker_r  <= speaker_s;
      seg_r      <= seg_s;
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign speaker  = speaker_r;
  assign seg      = seg_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign note_idx = note_idx_r;

endmodule
